// File: rtl/param_memory.sv
// Word-addressed data memory with configurable width/depth, byte-lane writes,
// 0..3 cycle read latency, post-reset zero fill and out-of-range flagging.
//
// state   | meaning
// S_CLEAR | zero-fill sequence: writes word clr_ctr each cycle, requests blocked
// S_READY | accepting one request per cycle
module param_memory #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  clr_ctr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              addr_err;
  logic              clr_we;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rsp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_ctr == IDX_W'(DEPTH - 1)) state_nxt = S_READY;
      S_READY: state_nxt = S_READY;
      default: state_nxt = S_READY;
    endcase
  end

  // Outputs are held low for the whole time rst is high, whatever the state
  // register holds, so the reset values appear asynchronously.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      req_ready = (state == S_READY);
      busy      = (state == S_CLEAR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   clr_ctr <= '0;
    else if (state == S_CLEAR) clr_ctr <= clr_ctr + IDX_W'(1);
  end

  // Range check at full address width plus headroom so DEPTH never truncates.
  assign addr_err = ({32'd0, req_addr} >= (ADDR_W + 32)'(DEPTH));
  assign acc      = req_valid & req_ready;
  assign clr_we   = (state == S_CLEAR) & ~rst;
  assign idx      = req_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ctr] <= '0;
    end else if (acc && req_we && !addr_err) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Pre-edge array contents give read-before-write on a same-cycle write.
  always_comb begin
    rd_word = '0;
    if (!addr_err) rd_word = mem[idx];
  end

  assign rsp_d = (acc && !req_we) ? rd_word : '0;

  generate
    if (READ_LAT == 0) begin : g_comb
      assign resp_valid = acc;
      assign resp_err   = acc & addr_err;
      assign resp_rdata = rsp_d;
    end else begin : g_pipe
      logic [READ_LAT-1:0] pv;
      logic [READ_LAT-1:0] pe;
      logic [DATA_W-1:0]   pd [READ_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv <= '0;
          pe <= '0;
          for (int i = 0; i < READ_LAT; i++) pd[i] <= '0;
        end else begin
          pv[0] <= acc;
          pe[0] <= acc & addr_err;
          pd[0] <= rsp_d;
          for (int i = 1; i < READ_LAT; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign resp_valid = pv[READ_LAT-1];
      assign resp_err   = pe[READ_LAT-1];
      assign resp_rdata = pd[READ_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench for param_memory: a pipelined wide-address instance (A)
// and a combinational no-clear instance (B), checked against an array model.
`timescale 1ns/1ps
module tb_param_memory;

  localparam int A_DEPTH = 1000;
  localparam int A_AW    = 40;
  localparam int A_LAT   = 3;
  localparam int B_DEPTH = 16;
  localparam int B_AW    = 32;
  localparam int B_LAT   = 0;
  localparam int MAXS    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [A_AW-1:0] a_req_addr  = '0;
  logic [31:0]     a_req_wdata = '0;
  logic [3:0]      a_req_be    = '0;
  logic            a_req_ready, a_resp_valid, a_resp_err, a_busy;
  logic [31:0]     a_resp_rdata;

  logic            b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [B_AW-1:0] b_req_addr  = '0;
  logic [31:0]     b_req_wdata = '0;
  logic [3:0]      b_req_be    = '0;
  logic            b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0]     b_resp_rdata;

  param_memory #(.DATA_W(32), .ADDR_W(A_AW), .DEPTH(A_DEPTH), .READ_LAT(A_LAT),
                 .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_be(a_req_be), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .busy(a_busy));

  param_memory #(.DATA_W(32), .ADDR_W(B_AW), .DEPTH(B_DEPTH), .READ_LAT(B_LAT),
                 .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_be(b_req_be), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .busy(b_busy));

  // Reference model: plain word arrays per instance
  logic [31:0] mdl_a [A_DEPTH];
  logic [31:0] mdl_b [B_DEPTH];

  // One slot per cycle of a burst; s_v=0 is an idle cycle
  bit          s_v  [MAXS];
  bit          s_we [MAXS];
  logic [63:0] s_addr [MAXS];
  logic [31:0] s_wd [MAXS];
  logic [3:0]  s_be [MAXS];
  int          nslot;
  logic [31:0] e_d [MAXS];
  logic        e_e [MAXS];
  logic        o_v [MAXS+8];
  logic [31:0] o_d [MAXS+8];
  logic        o_e [MAXS+8];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void clear_slots();
    nslot = 0;
  endfunction

  function automatic void add_slot(bit v, bit we, logic [63:0] addr,
                                   logic [31:0] wd, logic [3:0] be);
    s_v[nslot] = v; s_we[nslot] = we; s_addr[nslot] = addr;
    s_wd[nslot] = wd; s_be[nslot] = be;
    nslot++;
  endfunction

  function automatic void zero_model_a();
    for (int i = 0; i < A_DEPTH; i++) mdl_a[i] = '0;
  endfunction

  // Walk the burst in order: each request sees the array left by earlier ones.
  function automatic void predict(int inst);
    int          depth;
    int          a;
    logic [31:0] old, nw;
    depth = (inst != 0) ? B_DEPTH : A_DEPTH;
    for (int s = 0; s < nslot; s++) begin
      e_d[s] = '0;
      e_e[s] = 1'b0;
      if (s_v[s]) begin
        e_e[s] = (s_addr[s] >= 64'(depth));
        if (!e_e[s]) begin
          a   = int'(s_addr[s][31:0]);
          old = (inst != 0) ? mdl_b[a] : mdl_a[a];
          if (!s_we[s]) begin
            e_d[s] = old;
          end else begin
            nw = old;
            for (int l = 0; l < 4; l++) if (s_be[s][l]) nw[8*l +: 8] = s_wd[s][8*l +: 8];
            if (inst != 0) mdl_b[a] = nw;
            else           mdl_a[a] = nw;
          end
        end
      end
    end
  endfunction

  task automatic run_burst(input int inst);
    int lat;
    lat = (inst != 0) ? B_LAT : A_LAT;
    for (int t = 0; t < nslot + lat + 1; t++) begin
      @(negedge clk);
      if (inst == 0) begin
        a_req_valid = (t < nslot) ? s_v[t] : 1'b0;
        if (t < nslot) begin
          a_req_we = s_we[t]; a_req_addr = s_addr[t][A_AW-1:0];
          a_req_wdata = s_wd[t]; a_req_be = s_be[t];
        end
      end else begin
        b_req_valid = (t < nslot) ? s_v[t] : 1'b0;
        if (t < nslot) begin
          b_req_we = s_we[t]; b_req_addr = s_addr[t][B_AW-1:0];
          b_req_wdata = s_wd[t]; b_req_be = s_be[t];
        end
      end
      #1;
      o_v[t] = (inst == 0) ? a_resp_valid : b_resp_valid;
      o_d[t] = (inst == 0) ? a_resp_rdata : b_resp_rdata;
      o_e[t] = (inst == 0) ? a_resp_err   : b_resp_err;
    end
    @(negedge clk);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic count_clear(output int n, output bit ready_bad,
                             output bit resp_seen, output bit b_busy_seen);
    n = 0; ready_bad = 0; resp_seen = 0; b_busy_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4 * A_DEPTH && a_busy === 1'b1; k++) begin
      n++;
      if (a_req_ready !== 1'b0) ready_bad = 1;
      if (a_resp_valid !== 1'b0) resp_seen = 1;
      if (b_busy !== 1'b0) b_busy_seen = 1;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({a_req_ready, a_resp_valid, a_resp_err, a_busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_a_ctrl: got rdy/vld/err/busy=%b want 0000",
               {a_req_ready, a_resp_valid, a_resp_err, a_busy});
    end
    n_tests++;
    if (a_resp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_a_rdata: got %h want 0", a_resp_rdata);
    end
    n_tests++;
    if ({b_req_ready, b_resp_valid, b_resp_err, b_busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_b_ctrl: got rdy/vld/err/busy=%b want 0000",
               {b_req_ready, b_resp_valid, b_resp_err, b_busy});
    end
    n_tests++;
    if (b_resp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_b_rdata: got %h want 0", b_resp_rdata);
    end
  endtask

  task automatic test_clear();
    int n;
    bit rb, rs, bb;
    count_clear(n, rb, rs, bb);
    n_tests++;
    if (n != A_DEPTH) begin
      n_fail++; $display("FAIL clear_len: got %0d busy cycles want %0d", n, A_DEPTH);
    end
    n_tests++;
    if (rb || a_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_ready: ready during busy=%b, after=%b want 0/1", rb, a_req_ready);
    end
    n_tests++;
    if (bb || b_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL noclear_b: busy seen=%b ready=%b want 0/1", bb, b_req_ready);
    end
    zero_model_a();
    clear_slots();
    for (int i = 0; i < 16; i++) add_slot(1, 0, 64'(i), 0, 0);
    for (int i = 0; i < 8; i++) add_slot(1, 0, 64'($urandom_range(16, A_DEPTH - 1)), 0, 0);
    predict(0);
    run_burst(0);
    for (int t = 0; t < nslot + A_LAT + 1; t++) begin
      logic ev;
      ev = (t >= A_LAT && t - A_LAT < nslot) ? s_v[t - A_LAT] : 1'b0;
      n_tests++;
      if (o_v[t] !== ev) begin
        n_fail++; $display("FAIL clear_read valid cyc %0d: got %b want %b", t, o_v[t], ev);
      end else if (ev && (o_d[t] !== e_d[t - A_LAT] || o_e[t] !== e_e[t - A_LAT])) begin
        n_fail++; $display("FAIL clear_read data cyc %0d: got %h/%b want %h/%b",
                           t, o_d[t], o_e[t], e_d[t - A_LAT], e_e[t - A_LAT]);
      end
    end
  endtask

  // Fill every word of B so later reads have defined contents.
  task automatic test_fill_b();
    clear_slots();
    for (int i = 0; i < B_DEPTH; i++) add_slot(1, 1, 64'(i), $urandom, 4'hF);
    for (int i = 0; i < B_DEPTH; i++) add_slot(1, 0, 64'(i), 0, 0);
    predict(1);
    run_burst(1);
    for (int t = 0; t < nslot + B_LAT + 1; t++) begin
      logic ev;
      ev = (t >= B_LAT && t - B_LAT < nslot) ? s_v[t - B_LAT] : 1'b0;
      n_tests++;
      if (o_v[t] !== ev) begin
        n_fail++; $display("FAIL fill_b valid cyc %0d: got %b want %b", t, o_v[t], ev);
      end else if (ev && (o_d[t] !== e_d[t - B_LAT] || o_e[t] !== e_e[t - B_LAT])) begin
        n_fail++; $display("FAIL fill_b data cyc %0d: got %h/%b want %h/%b",
                           t, o_d[t], o_e[t], e_d[t - B_LAT], e_e[t - B_LAT]);
      end
    end
  endtask

  task automatic test_latency_order();
    clear_slots();
    add_slot(1, 1, 64'd5, 32'hDEADBEEF, 4'hF);
    add_slot(0, 0, 0, 0, 0);
    add_slot(1, 0, 64'd5, 0, 0);
    add_slot(1, 0, 64'd6, 0, 0);
    add_slot(1, 0, 64'd5, 0, 0);
    predict(0);
    run_burst(0);
    for (int t = 0; t < nslot + A_LAT + 1; t++) begin
      logic ev;
      ev = (t >= A_LAT && t - A_LAT < nslot) ? s_v[t - A_LAT] : 1'b0;
      n_tests++;
      if (o_v[t] !== ev) begin
        n_fail++; $display("FAIL lat_order valid cyc %0d: got %b want %b", t, o_v[t], ev);
      end else if (ev && (o_d[t] !== e_d[t - A_LAT] || o_e[t] !== e_e[t - A_LAT])) begin
        n_fail++; $display("FAIL lat_order data cyc %0d: got %h/%b want %h/%b",
                           t, o_d[t], o_e[t], e_d[t - A_LAT], e_e[t - A_LAT]);
      end
    end
  endtask

  task automatic test_byte_enable();
    clear_slots();
    add_slot(1, 1, 64'd3, 32'h11223344, 4'hF);
    add_slot(1, 1, 64'd3, 32'hAABBCCDD, 4'b0101);
    add_slot(1, 0, 64'd3, 0, 0);
    add_slot(1, 1, 64'd3, 32'h12345678, 4'b0000);
    add_slot(1, 0, 64'd3, 0, 0);
    add_slot(1, 1, 64'd3, 32'h99887766, 4'b1010);
    add_slot(1, 0, 64'd3, 0, 0);
    predict(0);
    run_burst(0);
    for (int t = 0; t < nslot + A_LAT + 1; t++) begin
      logic ev;
      ev = (t >= A_LAT && t - A_LAT < nslot) ? s_v[t - A_LAT] : 1'b0;
      n_tests++;
      if (o_v[t] !== ev) begin
        n_fail++; $display("FAIL byte_en valid cyc %0d: got %b want %b", t, o_v[t], ev);
      end else if (ev && (o_d[t] !== e_d[t - A_LAT] || o_e[t] !== e_e[t - A_LAT])) begin
        n_fail++; $display("FAIL byte_en data cyc %0d: got %h/%b want %h/%b",
                           t, o_d[t], o_e[t], e_d[t - A_LAT], e_e[t - A_LAT]);
      end
    end
  endtask

  task automatic test_same_cycle(input int inst);
    int lat;
    lat = (inst != 0) ? B_LAT : A_LAT;
    clear_slots();
    add_slot(1, 1, 64'd7, 32'h1, 4'hF);
    add_slot(1, 0, 64'd7, 0, 0);
    add_slot(1, 1, 64'd7, 32'h2, 4'hF);
    add_slot(1, 0, 64'd7, 0, 0);
    add_slot(1, 0, 64'd7, 0, 0);
    add_slot(1, 1, 64'd7, 32'h3, 4'hF);
    add_slot(1, 0, 64'd7, 0, 0);
    predict(inst);
    run_burst(inst);
    for (int t = 0; t < nslot + lat + 1; t++) begin
      logic ev;
      ev = (t >= lat && t - lat < nslot) ? s_v[t - lat] : 1'b0;
      n_tests++;
      if (o_v[t] !== ev) begin
        n_fail++; $display("FAIL same_cycle%0d valid cyc %0d: got %b want %b", inst, t, o_v[t], ev);
      end else if (ev && (o_d[t] !== e_d[t - lat] || o_e[t] !== e_e[t - lat])) begin
        n_fail++; $display("FAIL same_cycle%0d data cyc %0d: got %h/%b want %h/%b",
                           inst, t, o_d[t], o_e[t], e_d[t - lat], e_e[t - lat]);
      end
    end
  endtask

  task automatic test_out_of_range(input int inst);
    int lat;
    int dp;
    lat = (inst != 0) ? B_LAT : A_LAT;
    dp  = (inst != 0) ? B_DEPTH : A_DEPTH;
    clear_slots();
    add_slot(1, 1, 64'd0, 32'h0000_0055, 4'hF);
    add_slot(1, 1, 64'(dp - 1), 32'h0000_0066, 4'hF);
    add_slot(1, 0, 64'(dp), 0, 0);
    if (inst == 0) add_slot(1, 1, 64'h80_0000_03E8, 32'hFFFFFFFF, 4'hF);
    else           add_slot(1, 1, 64'hFFFF_FFF0, 32'hFFFFFFFF, 4'hF);
    add_slot(1, 1, 64'(dp), 32'hFFFFFFFF, 4'hF);
    add_slot(1, 1, 64'(1024), 32'hFFFFFFFF, 4'hF);
    add_slot(1, 0, 64'd0, 0, 0);
    add_slot(1, 0, 64'(dp - 1), 0, 0);
    add_slot(1, 0, 64'(1024), 0, 0);
    predict(inst);
    run_burst(inst);
    for (int t = 0; t < nslot + lat + 1; t++) begin
      logic ev;
      ev = (t >= lat && t - lat < nslot) ? s_v[t - lat] : 1'b0;
      n_tests++;
      if (o_v[t] !== ev) begin
        n_fail++; $display("FAIL oor%0d valid cyc %0d: got %b want %b", inst, t, o_v[t], ev);
      end else if (ev && (o_d[t] !== e_d[t - lat] || o_e[t] !== e_e[t - lat])) begin
        n_fail++; $display("FAIL oor%0d data cyc %0d: got %h/%b want %h/%b",
                           inst, t, o_d[t], o_e[t], e_d[t - lat], e_e[t - lat]);
      end
    end
  endtask

  task automatic test_random(input int inst);
    int lat;
    int r;
    logic [63:0] ad;
    lat = (inst != 0) ? B_LAT : A_LAT;
    clear_slots();
    for (int i = 0; i < 48; i++) begin
      r = $urandom_range(0, 9);
      if (inst == 0) begin
        if (r == 0)      ad = {24'd0, 8'($urandom), $urandom};
        else if (r == 1) ad = 64'(A_DEPTH + $urandom_range(0, 30));
        else             ad = 64'($urandom_range(0, 31));
      end else begin
        if (r == 0)      ad = {32'd0, $urandom};
        else if (r == 1) ad = 64'($urandom_range(B_DEPTH, 40));
        else             ad = 64'($urandom_range(0, B_DEPTH - 1));
      end
      add_slot(bit'($urandom_range(0, 5) != 0), bit'($urandom_range(0, 1)), ad,
               $urandom, 4'($urandom));
    end
    predict(inst);
    run_burst(inst);
    for (int t = 0; t < nslot + lat + 1; t++) begin
      logic ev;
      ev = (t >= lat && t - lat < nslot) ? s_v[t - lat] : 1'b0;
      n_tests++;
      if (o_v[t] !== ev) begin
        n_fail++; $display("FAIL random%0d valid cyc %0d: got %b want %b", inst, t, o_v[t], ev);
      end else if (ev && (o_d[t] !== e_d[t - lat] || o_e[t] !== e_e[t - lat])) begin
        n_fail++; $display("FAIL random%0d data cyc %0d: got %h/%b want %h/%b",
                           inst, t, o_d[t], o_e[t], e_d[t - lat], e_e[t - lat]);
      end
    end
  endtask

  // Two reads in flight, reset the cycle after; neither may ever respond.
  task automatic test_reset_midflight();
    int n;
    bit rb, rs, bb, early;
    early = 0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 40'd5;
    @(negedge clk);
    a_req_addr = 40'd3;
    @(negedge clk);
    a_req_valid = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (a_resp_valid !== 1'b0) early = 1;
      @(negedge clk);
    end
    count_clear(n, rb, rs, bb);
    n_tests++;
    if (early || rs) begin
      n_fail++; $display("FAIL midflight_resp: resp_valid seen (in rst=%b, in clear=%b) want none", early, rs);
    end
    n_tests++;
    if (n != A_DEPTH) begin
      n_fail++; $display("FAIL midflight_clear_len: got %0d busy cycles want %0d", n, A_DEPTH);
    end
    n_tests++;
    if (rb || a_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midflight_ready: ready during busy=%b, after=%b want 0/1", rb, a_req_ready);
    end
    zero_model_a();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_fill_b();
    test_latency_order();
    test_byte_enable();
    test_same_cycle(0);
    test_same_cycle(1);
    test_out_of_range(0);
    test_out_of_range(1);
    test_random(0);
    test_random(1);
    test_reset_midflight();
    test_random(0);
    test_random(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
Parametrised word-addressed data memory, successor to the fixed 1024x32 data/instruction memories. Width, depth, byte-lane write masking and read latency (0 = combinational, 1..3 = pipelined) are configurable. A post-reset clear sequencer zeroes every word. A valid/ready request port and a valid response port let the load/store stage tolerate any latency. Out-of-range accesses are flagged instead of aliasing.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 32, request address width (word address)
DEPTH, 1024, number of words; need not be a power of 2
READ_LAT, 1, cycles from request acceptance to response; legal 0..3
CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = go straight to READY

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i]
resp_valid  out  1  response present; single-cycle pulse per accepted request
resp_rdata  out  DATA_W  read data; 0 for writes and errors
resp_err  out  1  accepted request addressed a word >= DEPTH
busy  out  1  clear sequence in progress

Behaviour:
- Reset values, applied asynchronously while rst=1: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, response pipeline valids=0, clear counter=0.
- State machine:
  - States are CLEAR and READY.
  - On rst release the FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR: writes 0 to word ctr, then increments ctr, once per cycle. busy=1 and req_ready=0 throughout.
  - After writing word DEPTH-1 the FSM enters READY on the next edge. CLEAR lasts exactly DEPTH cycles.
  - READY: req_ready=1 and busy=0. One request is accepted per cycle when req_valid=1 and req_ready=1. No back-pressure on responses.
- Address check: err = (req_addr >= DEPTH), compared at full ADDR_W width with no truncation.
  - Erroring writes modify nothing.
  - Erroring reads return rdata=0.
- Write:
  - Each lane i with req_be[i]=1 updates on the acceptance edge; other lanes keep their value.
  - req_be=0 is legal: the array is unchanged and a response is still produced.
  - Write response: resp_rdata=0, resp_err=err.
- Read data is sampled from the array as it was before any same-cycle write (read-before-write), including a same-address write in the same cycle.
- Latency:
  - READ_LAT=0: resp_* are combinational from the accepted request in the same cycle.
  - READ_LAT=N>=1: resp_valid rises exactly N edges after acceptance.
  - Implemented as an N-stage pipeline of {valid, err, data}. Back-to-back requests give back-to-back responses in order.
- Read data is a snapshot at acceptance. A write to the same address accepted in a later cycle does not alter an in-flight read.
- Reset mid-operation: in-flight responses are discarded (no resp_valid after rst). The CLEAR sequence restarts from word 0. Array contents are undefined until CLEAR completes; if CLEAR_ON_RESET=0 they are retained.
- Requests presented while req_ready=0 are ignored and no response is generated. The requester must hold the request until accepted.

Test Plan:
- Clear: DEPTH=16, CLEAR_ON_RESET=1; release rst -> busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1; reads of addr 0..15 all return 0 with resp_err=0.
- Latency/ordering: READ_LAT=2; write 0xDEADBEEF to 5, then back-to-back reads of 5, 6, 5 -> resp_valid on 3 consecutive cycles, starting 2 edges after the first read, with data 0xDEADBEEF, 0x0, 0xDEADBEEF.
- Byte enables: word 3 = 0x11223344; write 0xAABBCCDD with be=4'b0101 -> read of 3 returns 0x11BB33DD; a write with be=0 leaves it unchanged.
- Same-cycle read/write (READ_LAT=0 and READ_LAT=1):
  - With READ_LAT=1, word 7 = 0x1; write 0x2 to 7 and then read 7 on the very next cycle -> returns 0x2.
  - With READ_LAT=0, an accepted read returns pre-edge contents: a read of 7 returns 0x1 when issued before the write edge.
- Out of range: DEPTH=1000, read addr 1000 and write 0xFFFFFFFF to addr 0x80000003E8 (wide ADDR_W) -> resp_err=1, rdata=0; word 1000 mod 1024 aliasing absent, word 0 unchanged.
- Reset mid-flight: READ_LAT=3, issue 2 reads, assert rst one cycle later -> no resp_valid ever emerges for them; CLEAR restarts at word 0 and runs a full DEPTH cycles.
